// File: rtl/adder_response_checker.sv
// Checks a 4-bit adder's responses against a+b+cin. It counts mismatches, latches the first failing vector
// and tracks which of the 512 input combinations have been seen; the session verdict is given after 512 accepted vectors.
module adder_response_checker #(
  parameter int ERR_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             cin,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic             error,
  output logic [ERR_W-1:0] err_cnt,
  output logic [8:0]       fail_vec,
  output logic             fail_valid,
  output logic             done,
  output logic             covered,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [9:0]   vec_cnt;
  logic [511:0] bitmap;

  logic [4:0]       expected;
  logic [8:0]       idx;
  logic             accept;
  logic             mismatch;
  logic             last;
  logic [ERR_W-1:0] err_cnt_nxt;
  logic [511:0]     bitmap_nxt;

  assign expected = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign idx      = {cin, b, a};
  // A start in the same cycle takes priority and discards the vector.
  assign accept   = (state == RUN) && vld && !start;
  assign mismatch = (expected != {cout, sum});
  assign last     = accept && (vec_cnt == 10'd511);

  assign err_cnt_nxt = (accept && mismatch && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
  assign bitmap_nxt  = bitmap | (512'(1) << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_cnt    <= '0;
      bitmap     <= '0;
      error      <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      done       <= 1'b0;
      covered    <= 1'b0;
      pass       <= 1'b0;
    end else begin
      error <= accept && mismatch;
      if (start) begin
        state      <= RUN;
        vec_cnt    <= '0;
        bitmap     <= '0;
        err_cnt    <= '0;
        fail_vec   <= '0;
        fail_valid <= 1'b0;
        done       <= 1'b0;
        covered    <= 1'b0;
        pass       <= 1'b0;
      end else if (accept) begin
        vec_cnt <= vec_cnt + 10'd1;
        err_cnt <= err_cnt_nxt;
        bitmap  <= bitmap_nxt;
        if (mismatch && !fail_valid) begin
          fail_vec   <= idx;
          fail_valid <= 1'b1;
        end
        // Verdict uses the next-state values so the final vector is included.
        if (last) begin
          state   <= DONE;
          done    <= 1'b1;
          covered <= &bitmap_nxt;
          pass    <= (&bitmap_nxt) && (err_cnt_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker; expected error pulses go through a scoreboard queue.
module tb_adder_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vld = 1'b0;
  logic [3:0] a = '0, b = '0, sum = '0;
  logic       cin = 1'b0, cout = 1'b0;

  logic       error, fail_valid, done, covered, pass;
  logic [9:0] err_cnt;
  logic [8:0] fail_vec;
  logic       error_s, fail_valid_s, done_s, covered_s, pass_s;
  logic [1:0] err_cnt_s;
  logic [8:0] fail_vec_s;

  int checks = 0;
  int errors = 0;

  logic  sb[$];
  logic  m_run = 1'b0;
  int    m_cnt = 0;

  always #5 clk = ~clk;

  adder_response_checker #(.ERR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .error(error), .err_cnt(err_cnt), .fail_vec(fail_vec),
    .fail_valid(fail_valid), .done(done), .covered(covered), .pass(pass)
  );

  adder_response_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .error(error_s), .err_cnt(err_cnt_s), .fail_vec(fail_vec_s),
    .fail_valid(fail_valid_s), .done(done_s), .covered(covered_s), .pass(pass_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_error"}, {31'b0, error}, 0);
    chk({tag, "_err_cnt"}, {22'b0, err_cnt}, 0);
    chk({tag, "_fail_vec"}, {23'b0, fail_vec}, 0);
    chk({tag, "_fail_valid"}, {31'b0, fail_valid}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_covered"}, {31'b0, covered}, 0);
    chk({tag, "_pass"}, {31'b0, pass}, 0);
  endtask

  // One clock: drive inputs, push the expected error pulse, then pop and compare after the edge.
  task automatic step(input logic s, input logic v, input logic [3:0] ta, input logic [3:0] tb,
                      input logic tc, input logic [3:0] ts, input logic tco);
    logic [4:0] e;
    logic       exp_err;
    start = s; vld = v; a = ta; b = tb; cin = tc; sum = ts; cout = tco;
    e = {1'b0, ta} + {1'b0, tb} + {4'b0000, tc};
    sb.push_back(v && !s && m_run && (e != {tco, ts}));
    if (s) begin
      m_run = 1'b1;
      m_cnt = 0;
    end else if (v && m_run) begin
      m_cnt++;
      if (m_cnt == 512) m_run = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_err = sb.pop_front();
    chk("error", {31'b0, error}, {31'b0, exp_err});
    chk("error_sat", {31'b0, error_s}, {31'b0, exp_err});
  endtask

  // mode 0 correct, 1 cout inverted, 2 sum forced to 0 at vector 0x153, 3 always the zero vector
  task automatic vec(input int i, input int mode);
    logic [8:0] x;
    logic [4:0] e;
    logic [3:0] ts;
    logic       tco;
    x = (mode == 3) ? 9'h000 : i[8:0];
    e = {1'b0, x[3:0]} + {1'b0, x[7:4]} + {4'b0000, x[8]};
    ts = e[3:0];
    tco = e[4];
    if (mode == 1) tco = ~tco;
    if (mode == 2 && x == 9'h153) ts = 4'h0;
    step(1'b0, 1'b1, x[3:0], x[7:4], x[8], ts, tco);
  endtask

  task automatic do_start();
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full correct ascending session
    do_start();
    chk_zero("after_start");
    for (int i = 0; i < 511; i++) vec(i, 0);
    chk("pre_done", {31'b0, done}, 0);
    vec(511, 0);
    chk("s1_done", {31'b0, done}, 1);
    chk("s1_covered", {31'b0, covered}, 1);
    chk("s1_pass", {31'b0, pass}, 1);
    chk("s1_err_cnt", {22'b0, err_cnt}, 0);
    vec(7, 1);  // ignored while in DONE
    chk("done_ignore_cnt", {22'b0, err_cnt}, 0);
    chk("done_hold", {31'b0, done}, 1);

    // One faulty vector at 0x153
    do_start();
    chk("restart_done_clr", {31'b0, done}, 0);
    for (int i = 0; i < 512; i++) vec(i, 2);
    chk("s2_done", {31'b0, done}, 1);
    chk("s2_err_cnt", {22'b0, err_cnt}, 1);
    chk("s2_fail_vec", {23'b0, fail_vec}, 32'h153);
    chk("s2_fail_valid", {31'b0, fail_valid}, 1);
    chk("s2_pass", {31'b0, pass}, 0);
    chk("s2_covered", {31'b0, covered}, 1);

    // 512 duplicates of the zero vector
    do_start();
    for (int i = 0; i < 512; i++) vec(i, 3);
    chk("s3_done", {31'b0, done}, 1);
    chk("s3_covered", {31'b0, covered}, 0);
    chk("s3_pass", {31'b0, pass}, 0);
    chk("s3_err_cnt", {22'b0, err_cnt}, 0);

    // Every vector wrong: saturation and a mismatching final vector
    do_start();
    for (int i = 0; i < 512; i++) vec(i, 1);
    chk("s4_done_with_last_err", {31'b0, done}, 1);
    chk("s4_err_cnt", {22'b0, err_cnt}, 512);
    chk("s4_sat_err_cnt", {30'b0, err_cnt_s}, 3);
    chk("s4_sat_fail_vec", {23'b0, fail_vec_s}, 0);
    chk("s4_sat_pass", {31'b0, pass_s}, 0);
    chk("s4_sat_done", {31'b0, done_s}, 1);

    // Errors, restart mid-run with a discarded wrong vector, then a clean session
    do_start();
    for (int i = 0; i < 200; i++) vec(i, 1);
    chk("s5_err_cnt", {22'b0, err_cnt}, 200);
    chk("s5_fail_valid", {31'b0, fail_valid}, 1);
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1);
    chk("s5_restart_cnt", {22'b0, err_cnt}, 0);
    for (int i = 0; i < 512; i++) vec(i, 0);
    chk("s5_err_cnt_final", {22'b0, err_cnt}, 0);
    chk("s5_fail_valid_final", {31'b0, fail_valid}, 0);
    chk("s5_pass", {31'b0, pass}, 1);

    // Reset mid-session, then vld without start
    do_start();
    for (int i = 0; i < 100; i++) vec(i, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    m_run = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 520; i++) vec(i, 1);
    chk("post_reset_done", {31'b0, done}, 0);
    chk("post_reset_err_cnt", {22'b0, err_cnt}, 0);
    chk("post_reset_fail_valid", {31'b0, fail_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_response_checker.md
ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 The block SHALL have parameter ERR_W, default 10, giving the width of the error counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin or restart a test session.
REQ-005 The block SHALL have port vld, input, 1, meaning a, b, cin, sum and cout are valid this cycle.
REQ-006 The block SHALL have ports a and b, input, 4 bits each: the operands applied to the adder under test.
REQ-007 The block SHALL have port cin, input, 1, the carry-in applied to the adder under test.
REQ-008 The block SHALL have ports sum (input, 4) and cout (input, 1): the response of the adder under test.
REQ-009 The block SHALL have port error, output, 1, a one-cycle pulse flagging a mismatching vector.
REQ-010 The block SHALL have port err_cnt, output, ERR_W, the number of mismatches in the current session.
REQ-011 The block SHALL have port fail_vec, output, 9, holding {cin,b,a} of the first mismatch; fail_valid, output, 1, marks it valid.
REQ-012 The block SHALL have ports done (output, 1), covered (output, 1) and pass (output, 1): session finished, all 512 input combinations seen, and overall verdict.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE. It resets to IDLE.
REQ-014 In IDLE or DONE, start=1 SHALL move the FSM to RUN on the next edge. The same edge SHALL clear the vector counter, err_cnt, fail_valid, fail_vec, the coverage bitmap, done, covered and pass.
REQ-015 In RUN, start=1 SHALL restart the session with the same clearing as REQ-014. Any vld on that cycle SHALL be discarded.
REQ-016 In RUN with vld=1, the block SHALL compute the expected value as the 5-bit sum a+b+cin, zero-extended, and compare it against {cout,sum}.
REQ-017 On a mismatch, error SHALL be 1 for exactly the cycle after the sample (latency 1). error SHALL be 0 otherwise.
REQ-018 err_cnt SHALL increment by 1 per mismatch and saturate at 2^ERR_W-1.
REQ-019 The first mismatch of a session SHALL load fail_vec and set fail_valid. Later mismatches SHALL NOT change fail_vec.
REQ-020 Every accepted vector SHALL set bitmap bit {cin,b,a} of a 512-bit coverage bitmap. Duplicate vectors SHALL count as accepted vectors.
REQ-021 On acceptance of the 512th vector, the FSM SHALL enter DONE. From the next cycle, done SHALL be 1 and remain 1 until a start or reset.
REQ-022 In DONE, covered SHALL equal the AND of all bitmap bits. pass SHALL equal covered AND (err_cnt==0).
REQ-023 While not in DONE, done, covered and pass SHALL be 0.
REQ-024 vld SHALL be ignored in IDLE and DONE: no counting, no error pulse, no bitmap update.
REQ-025 If the 512th vector mismatches, its error pulse and done=1 SHALL appear in the same cycle, and err_cnt SHALL already include it.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force the FSM to IDLE and set error, err_cnt, fail_vec, fail_valid, done, covered and pass to 0. It SHALL also clear the vector counter and bitmap.
REQ-027 Reset asserted during RUN SHALL abandon the session. No done pulse or partial verdict SHALL appear after release.

Verification
REQ-028 Reset, start, then 512 correct vectors in {cin,b,a} ascending order with vld=1 every cycle -> done=1 one cycle after the last vector, covered=1, pass=1, err_cnt=0, error never asserted.
REQ-029 As REQ-028, but with sum forced to 4'h0 when a=3, b=5, cin=1 -> error=1 for exactly one cycle after that vector, err_cnt=1, fail_vec=9'h153, fail_valid=1, pass=0, covered=1.
REQ-030 Start, then 512 correct vectors all equal to a=0, b=0, cin=0 -> done=1, covered=0, pass=0, err_cnt=0.
REQ-031 Start, then 100 correct vectors, then rst_n pulsed low mid-cycle -> all outputs 0 immediately. After release, vld stimulus without a start -> no error pulses and done stays 0.
REQ-032 Start, then 200 vectors with cout inverted on all of them, then start again, then 512 correct ascending vectors -> the second session ends with err_cnt=0, fail_valid=0, pass=1.
REQ-033 With ERR_W=2, a full session with every vector wrong -> err_cnt=3 (saturated), fail_vec=9'h000, pass=0.
